perf_report_serializer: RTL and testbench

//   Downstream consumer of the test runner's performance counters. On each new

---
 rtl/perf_report_serializer_if.sv | 13 +
 rtl/perf_report_serializer.sv | 140 ++++++++++++++
 tb/tb_perf_report_serializer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/perf_report_serializer_if.sv
// Byte-wide valid/ready stream carrying performance report frames.
//   out_data  : frame byte, driven by the master
//   out_valid : out_data holds a byte waiting for acceptance
//   out_ready : slave accepts the presented byte this cycle
// Transfer happens on a rising clock edge where out_valid and out_ready are both 1.
interface perf_report_serializer_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/perf_report_serializer.sv
// perf_report_serializer
//   Snapshots the runner's performance counters on each rising edge of done and
//   streams them as an 18-byte frame:
//     HEADER_BYTE, num_inst, num_noops, num_mispredicts, result (each MSB byte
//     first), then a checksum byte (XOR of the 16 payload bytes, or 8'h00 when
//     CSUM_EN is 0).
// Ports
//   clk               system clock, all state on posedge
//   rst               asynchronous, active-high reset
//   done_i            runner completion flag (level); a rising edge starts a frame
//   num_inst_i        instruction count
//   num_noops_i       noop count
//   num_mispredicts_i mispredict count
//   result_i          program result register
//   out_if            byte stream (master side)
//   busy_o            frame in progress
//   frame_count_o     completed frames, wraps 255->0
//   overrun_o         sticky: done rose while a frame was in progress
module perf_report_serializer #(
  parameter logic [7:0] HEADER_BYTE = 8'hA5,
  parameter bit         CSUM_EN     = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done_i,
  input  logic [31:0]              num_inst_i,
  input  logic [31:0]              num_noops_i,
  input  logic [31:0]              num_mispredicts_i,
  input  logic [31:0]              result_i,
  perf_report_serializer_if.master out_if,
  output logic                     busy_o,
  output logic [7:0]               frame_count_o,
  output logic                     overrun_o
);

  typedef enum logic [1:0] {IDLE, HDR, PAY, CSUM} state_t;

  state_t       state_q;
  logic         done_q;
  logic [127:0] payload_q;   // snapshot; shifts left one byte per payload transfer
  logic [3:0]   idx_q;       // payload byte index 0..15
  logic [7:0]   csum_q;      // XOR of payload bytes already sent
  logic [7:0]   data_q;
  logic         valid_q;
  logic         busy_q;
  logic         overrun_q;
  logic [7:0]   frame_count_q;

  logic         start;
  logic         xfer;
  logic [7:0]   csum_d;

  assign start  = done_i & ~done_q;
  assign xfer   = valid_q & out_if.out_ready;
  // Running XOR including the payload byte being transferred right now.
  assign csum_d = csum_q ^ data_q;

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign busy_o           = busy_q;
  assign frame_count_o    = frame_count_q;
  assign overrun_o        = overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      // Treat done as already high so a level held through reset release
      // does not start a frame.
      done_q        <= 1'b1;
      payload_q     <= '0;
      idx_q         <= '0;
      csum_q        <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      done_q <= done_i;
      case (state_q)
        IDLE: begin
          if (start) begin
            payload_q <= {num_inst_i, num_noops_i, num_mispredicts_i, result_i};
            csum_q    <= '0;
            idx_q     <= '0;
            data_q    <= HEADER_BYTE;
            valid_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= HDR;
          end
        end
        HDR: begin
          if (start) overrun_q <= 1'b1;
          if (xfer) begin
            data_q  <= payload_q[127:120];
            idx_q   <= '0;
            state_q <= PAY;
          end
        end
        PAY: begin
          if (start) overrun_q <= 1'b1;
          if (xfer) begin
            csum_q    <= csum_d;
            payload_q <= {payload_q[119:0], 8'h00};
            if (idx_q == 4'd15) begin
              data_q  <= CSUM_EN ? csum_d : 8'h00;
              state_q <= CSUM;
            end else begin
              data_q <= payload_q[119:112];
              idx_q  <= idx_q + 4'd1;
            end
          end
        end
        CSUM: begin
          if (xfer) begin
            frame_count_q <= frame_count_q + 8'd1;
            // A start coinciding with the final transfer chains straight into
            // the next header with no idle cycle.
            if (start) begin
              payload_q <= {num_inst_i, num_noops_i, num_mispredicts_i, result_i};
              csum_q    <= '0;
              idx_q     <= '0;
              data_q    <= HEADER_BYTE;
              state_q   <= HDR;
            end else begin
              data_q  <= '0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else if (start) begin
            overrun_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perf_report_serializer.sv
module tb_perf_report_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        done_a, done_b;
  logic [31:0] inst_a, noops_a, mis_a, res_a;
  logic [31:0] inst_b, noops_b, mis_b, res_b;
  logic        busy_a, overrun_a, busy_b, overrun_b;
  logic [7:0]  fc_a, fc_b;

  perf_report_serializer_if ifa();
  perf_report_serializer_if ifb();

  perf_report_serializer #(.HEADER_BYTE(8'hA5), .CSUM_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .done_i(done_a),
    .num_inst_i(inst_a), .num_noops_i(noops_a),
    .num_mispredicts_i(mis_a), .result_i(res_a),
    .out_if(ifa), .busy_o(busy_a), .frame_count_o(fc_a), .overrun_o(overrun_a)
  );

  perf_report_serializer #(.HEADER_BYTE(8'hA5), .CSUM_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .done_i(done_b),
    .num_inst_i(inst_b), .num_noops_i(noops_b),
    .num_mispredicts_i(mis_b), .result_i(res_b),
    .out_if(ifb), .busy_o(busy_b), .frame_count_o(fc_b), .overrun_o(overrun_b)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] rx_a[$];
  logic [7:0] rx_b[$];
  logic [7:0] exp_f[18];
  int         exp_fc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference frame built straight from the frame layout rules.
  task automatic build_expected(input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3,
                                input bit csum_en);
    logic [31:0] w[4];
    logic [31:0] v;
    logic [7:0]  cs;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    cs = 8'h00;
    exp_f[0] = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < 4; b++) begin
        v = w[i] >> (8 * (3 - b));
        exp_f[1 + 4 * i + b] = v[7:0];
        cs = cs ^ v[7:0];
      end
    end
    exp_f[17] = csum_en ? cs : 8'h00;
  endtask

  // One clock: record transfers seen at the edge, check stall stability.
  task automatic tick();
    logic       va, vb, ra, rb;
    logic [7:0] da, db;
    va = ifa.out_valid; da = ifa.out_data; ra = ifa.out_ready;
    vb = ifb.out_valid; db = ifb.out_data; rb = ifb.out_ready;
    @(posedge clk);
    #1;
    if (va && ra) rx_a.push_back(da);
    if (vb && rb) rx_b.push_back(db);
    if (va && !ra && !rst) begin
      check("stall_valid", {31'b0, ifa.out_valid}, 32'd1);
      check("stall_data", {24'b0, ifa.out_data}, {24'b0, da});
    end
  endtask

  task automatic wait_bytes_a(input int n, input bit rand_ready, output int cycles);
    cycles = 0;
    while (rx_a.size() < n && cycles < 2000) begin
      ifa.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      cycles++;
    end
    ifa.out_ready = 1'b1;
    if (rx_a.size() < n) check("timeout_a", rx_a.size(), n);
  endtask

  task automatic start_frame_a();
    done_a = 1'b0;
    tick();
    done_a = 1'b1;
    tick();
  endtask

  task automatic compare_frame_a(input string tag);
    if (rx_a.size() < 18) begin
      check({tag, "_len"}, rx_a.size(), 18);
    end else begin
      for (int i = 0; i < 18; i++) check(tag, {24'b0, rx_a[i]}, {24'b0, exp_f[i]});
      for (int i = 0; i < 18; i++) void'(rx_a.pop_front());
    end
  endtask

  task automatic set_basic_a();
    inst_a = 32'h10; noops_a = 32'h04; mis_a = 32'h01; res_a = 32'h2A;
  endtask

  initial begin
    int          cyc;
    logic [143:0] lit;

    rst = 1'b1;
    done_a = 1'b1; done_b = 1'b0;
    inst_a = '0; noops_a = '0; mis_a = '0; res_a = '0;
    inst_b = '0; noops_b = '0; mis_b = '0; res_b = '0;
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;
    exp_fc = 0;
    tick(); tick();
    check("rst_valid", {31'b0, ifa.out_valid}, 32'd0);
    check("rst_data", {24'b0, ifa.out_data}, 32'd0);
    check("rst_busy", {31'b0, busy_a}, 32'd0);
    check("rst_fc", {24'b0, fc_a}, 32'd0);
    check("rst_overrun", {31'b0, overrun_a}, 32'd0);

    // done already high at release must not start a frame
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("no_start_at_release", rx_a.size() + {31'b0, ifa.out_valid}, 0);

    // Basic frame at full rate
    set_basic_a();
    start_frame_a();
    check("hdr_latency_valid", {31'b0, ifa.out_valid}, 32'd1);
    check("hdr_latency_data", {24'b0, ifa.out_data}, 32'hA5);
    check("hdr_busy", {31'b0, busy_a}, 32'd1);
    wait_bytes_a(18, 1'b0, cyc);
    check("basic_cycles", cyc, 18);
    lit = {8'hA5, 32'h10, 32'h04, 32'h01, 32'h2A, 8'h3F};
    for (int i = 0; i < 18 && i < rx_a.size(); i++)
      check("basic_literal", {24'b0, rx_a[i]}, {24'b0, lit[143 - 8 * i -: 8]});
    build_expected(inst_a, noops_a, mis_a, res_a, 1'b1);
    compare_frame_a("basic_model");
    exp_fc++;
    check("basic_fc", {24'b0, fc_a}, exp_fc);
    check("basic_busy_after", {31'b0, busy_a}, 32'd0);
    check("basic_valid_after", {31'b0, ifa.out_valid}, 32'd0);

    // Backpressure: same inputs, then random payloads
    for (int f = 0; f < 6; f++) begin
      if (f == 0) set_basic_a();
      else begin
        inst_a = $urandom; noops_a = $urandom; mis_a = $urandom; res_a = $urandom;
      end
      build_expected(inst_a, noops_a, mis_a, res_a, 1'b1);
      start_frame_a();
      wait_bytes_a(18, 1'b1, cyc);
      compare_frame_a("bp_frame");
      exp_fc++;
      check("bp_fc", {24'b0, fc_a}, exp_fc);
    end

    // Back-to-back: start on the checksum transfer cycle
    set_basic_a();
    build_expected(inst_a, noops_a, mis_a, res_a, 1'b1);
    start_frame_a();
    wait_bytes_a(16, 1'b0, cyc);
    done_a = 1'b0;
    wait_bytes_a(17, 1'b0, cyc);
    done_a = 1'b1;
    inst_a = 32'hDEADBEEF;
    tick();
    check("b2b_valid", {31'b0, ifa.out_valid}, 32'd1);
    check("b2b_hdr", {24'b0, ifa.out_data}, 32'hA5);
    check("b2b_busy", {31'b0, busy_a}, 32'd1);
    compare_frame_a("b2b_first");
    exp_fc++;
    check("b2b_fc1", {24'b0, fc_a}, exp_fc);
    build_expected(inst_a, noops_a, mis_a, res_a, 1'b1);
    wait_bytes_a(18, 1'b0, cyc);
    compare_frame_a("b2b_second");
    exp_fc++;
    check("b2b_fc2", {24'b0, fc_a}, exp_fc);
    check("b2b_no_overrun", {31'b0, overrun_a}, 32'd0);

    // Snapshot / overrun: inputs change and done re-rises mid-frame
    set_basic_a();
    build_expected(inst_a, noops_a, mis_a, res_a, 1'b1);
    start_frame_a();
    wait_bytes_a(5, 1'b0, cyc);
    inst_a = '1; noops_a = '1; mis_a = '1; res_a = '1;
    done_a = 1'b0;
    tick();
    done_a = 1'b1;
    tick();
    check("overrun_set", {31'b0, overrun_a}, 32'd1);
    wait_bytes_a(18, 1'b0, cyc);
    compare_frame_a("snapshot");
    exp_fc++;
    for (int i = 0; i < 6; i++) tick();
    check("no_second_frame", rx_a.size() + {31'b0, ifa.out_valid}, 0);
    check("overrun_fc", {24'b0, fc_a}, exp_fc);
    check("overrun_sticky", {31'b0, overrun_a}, 32'd1);

    // Reset mid-frame
    set_basic_a();
    build_expected(inst_a, noops_a, mis_a, res_a, 1'b1);
    start_frame_a();
    wait_bytes_a(9, 1'b0, cyc);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", {31'b0, ifa.out_valid}, 32'd0);
    check("rst_mid_fc", {24'b0, fc_a}, 32'd0);
    check("rst_mid_overrun", {31'b0, overrun_a}, 32'd0);
    check("rst_mid_busy", {31'b0, busy_a}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    rx_a.delete();
    for (int i = 0; i < 5; i++) tick();
    check("rst_no_resume", rx_a.size() + {31'b0, ifa.out_valid}, 0);
    start_frame_a();
    check("rst_restart_hdr", {24'b0, ifa.out_data}, 32'hA5);
    wait_bytes_a(18, 1'b0, cyc);
    compare_frame_a("rst_restart");
    check("rst_restart_fc", {24'b0, fc_a}, 32'd1);

    // Checksum disabled, frame counter wrap over 256 frames
    for (int k = 0; k < 256; k++) begin
      int budget;
      inst_b = $urandom; noops_b = $urandom; mis_b = $urandom; res_b = $urandom;
      build_expected(inst_b, noops_b, mis_b, res_b, 1'b0);
      done_b = 1'b0;
      tick();
      done_b = 1'b1;
      tick();
      budget = 0;
      while (rx_b.size() < 18 && budget < 100) begin
        tick();
        budget++;
      end
      if (rx_b.size() < 18) begin
        check("timeout_b", rx_b.size(), 18);
        rx_b.delete();
      end else begin
        if (k == 0) begin
          for (int i = 0; i < 18; i++) check("nocsum_frame", {24'b0, rx_b[i]}, {24'b0, exp_f[i]});
        end
        check("nocsum_hdr", {24'b0, rx_b[0]}, 32'hA5);
        check("nocsum_last", {24'b0, rx_b[17]}, 32'h00);
        check("nocsum_inst_msb", {24'b0, rx_b[1]}, {24'b0, exp_f[1]});
        check("wrap_fc", {24'b0, fc_b}, (k + 1) % 256);
        rx_b.delete();
      end
    end
    check("wrap_final_fc", {24'b0, fc_b}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
